// File: rtl/i2c_slave_write.sv
// Write-only I2C target: matches a 7-bit address + W, ACKs two bytes, then
// presents {byte1,byte2} on regdata with a one-cycle valid strobe.
module i2c_slave_write #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        SCLK,
    inout  wire         SDIN,
    output logic [15:0] regdata,
    output logic        valid,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_d_q;
    logic                   sda_d_q;
    logic [3:0]             bitcnt_q;
    logic [7:0]             shift_q;
    logic [7:0]             byte1_q;
    logic [15:0]            regdata_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   error_q;
    logic                   drive0_q;

    logic       scl_s;
    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       in_xfer;
    logic [7:0] shift_d;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d_q;
    assign scl_fall  = ~scl_s & scl_d_q;
    assign start_det = scl_s & scl_d_q & ~sda_s & sda_d_q;
    assign stop_det  = scl_s & scl_d_q & sda_s & ~sda_d_q;
    assign shift_d   = {shift_q[6:0], sda_s};
    // A START/STOP here means the master abandoned an acknowledged write.
    assign in_xfer   = (state_q inside {ACK_A, BYTE1, ACK_1, BYTE2, ACK_2});

    assign SDIN    = drive0_q ? 1'b0 : 1'bz;
    assign regdata = regdata_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign error   = error_q;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_d_q    <= 1'b1;
            sda_d_q    <= 1'b1;
            bitcnt_q   <= 4'd0;
            shift_q    <= 8'h00;
            byte1_q    <= 8'h00;
            regdata_q  <= 16'h0000;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            drive0_q   <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCLK};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDIN};
            scl_d_q    <= scl_s;
            sda_d_q    <= sda_s;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;

            if (stop_det) begin
                error_q  <= in_xfer;
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                drive0_q <= 1'b0;
                bitcnt_q <= 4'd0;
            end else if (start_det) begin
                error_q  <= in_xfer;
                state_q  <= ADDR;
                busy_q   <= 1'b0;
                drive0_q <= 1'b0;
                bitcnt_q <= 4'd0;
            end else begin
                case (state_q)
                    ADDR, BYTE1, BYTE2: begin
                        if (scl_rise) begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                if (state_q == ADDR) begin
                                    if (shift_d[7:1] == DEV_ADDR && !shift_d[0]) begin
                                        state_q <= ACK_A;
                                        busy_q  <= 1'b1;
                                    end else begin
                                        state_q <= IGNORE;
                                    end
                                end else if (state_q == BYTE1) begin
                                    byte1_q <= shift_d;
                                    state_q <= ACK_1;
                                end else begin
                                    state_q <= ACK_2;
                                end
                            end
                        end
                    end
                    // First SCL fall starts the ACK low, the second one ends it.
                    ACK_A, ACK_1, ACK_2: begin
                        if (scl_fall) begin
                            if (!drive0_q) begin
                                drive0_q <= 1'b1;
                            end else begin
                                drive0_q <= 1'b0;
                                bitcnt_q <= 4'd0;
                                if (state_q == ACK_A) begin
                                    state_q <= BYTE1;
                                end else if (state_q == ACK_1) begin
                                    state_q <= BYTE2;
                                end else begin
                                    regdata_q <= {byte1_q, shift_q};
                                    valid_q   <= 1'b1;
                                    state_q   <= IGNORE;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_write.sv
// Bench for i2c_slave_write: bit-banged I2C master, table vectors, randomized
// transactions against a transaction-level model, and hand-built corner cases.
module tb_i2c_slave_write;

    localparam logic [6:0] DEV = 7'h1A;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl_r = 1'b1;
    logic        m_drv0 = 1'b0;
    wire         sda;
    logic [15:0] regdata;
    logic        valid;
    logic        busy;
    logic        error;

    pullup (sda);
    assign sda = m_drv0 ? 1'b0 : 1'bz;

    i2c_slave_write #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .SCLK    (scl_r),
        .SDIN    (sda),
        .regdata (regdata),
        .valid   (valid),
        .busy    (busy),
        .error   (error)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int cnt_valid = 0;
    int cnt_errp = 0;
    int cnt_slow = 0;

    always begin
        @(posedge CLK);
        #2;
        if (valid) cnt_valid++;
        if (error) cnt_errp++;
        if (sda == 1'b0 && !m_drv0) cnt_slow++;
    end

    typedef struct {
        logic [7:0]  adr;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [7:0]  d3;
        int          nd;
        logic [3:0]  exp_ack;
        int          exp_valid;
        logic [15:0] exp_reg;
        int          exp_err;
    } vec_t;

    vec_t        tbl [8];
    logic [15:0] model_reg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        tick(4); m_drv0 = ~b;
        tick(4); scl_r = 1'b1;
        tick(8); scl_r = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i >= 8 - n; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack, output logic bsy);
        send_bits(b, 8);
        tick(4); m_drv0 = 1'b0;
        tick(4); scl_r = 1'b1;
        tick(4); ack = (sda == 1'b0); bsy = busy;
        tick(4); scl_r = 1'b0;
    endtask

    task automatic bus_start();
        if (!scl_r) begin
            tick(4); m_drv0 = 1'b0;
            tick(4); scl_r = 1'b1;
        end
        tick(8); m_drv0 = 1'b1;
        tick(8); scl_r = 1'b0;
    endtask

    task automatic bus_stop();
        tick(4); m_drv0 = 1'b1;
        tick(4); scl_r = 1'b1;
        tick(8); m_drv0 = 1'b0;
        tick(16);
    endtask

    // Transaction-level expectation: what a two-byte write target must do.
    function automatic vec_t model(input vec_t v, input logic [15:0] prev);
        vec_t r = v;
        logic match = (v.adr == {DEV, 1'b0});
        r.exp_ack   = {1'b0, match && v.nd >= 2, match && v.nd >= 1, match};
        r.exp_valid = (match && v.nd >= 2) ? 1 : 0;
        r.exp_reg   = (match && v.nd >= 2) ? {v.d1, v.d2} : prev;
        r.exp_err   = (match && v.nd < 2) ? 1 : 0;
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        int v0 = cnt_valid;
        int e0 = cnt_errp;
        int s0 = cnt_slow;
        logic ak, bs;
        logic [7:0] db [3];
        db[0] = v.d1; db[1] = v.d2; db[2] = v.d3;
        bus_start();
        send_byte(v.adr, ak, bs);
        chk({nm, "_ack_adr"}, 32'(ak), 32'(v.exp_ack[0]));
        chk({nm, "_busy"}, 32'(bs), 32'(v.exp_ack[0]));
        for (int i = 0; i < v.nd; i++) begin
            send_byte(db[i], ak, bs);
            chk($sformatf("%s_ack_d%0d", nm, i + 1), 32'(ak), 32'(v.exp_ack[i + 1]));
        end
        bus_stop();
        chk({nm, "_valid_cnt"}, 32'(cnt_valid - v0), 32'(v.exp_valid));
        chk({nm, "_regdata"}, 32'(regdata), 32'(v.exp_reg));
        chk({nm, "_error_cnt"}, 32'(cnt_errp - e0), 32'(v.exp_err));
        chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
        chk({nm, "_sda_pulled"}, 32'(cnt_slow > s0), 32'(v.exp_ack != 4'b0));
        model_reg = v.exp_reg;
    endtask

    initial begin
        logic ak, bs;
        int v0, e0, s0;
        vec_t rv;

        tbl[0] = '{8'h34, 8'h1E, 8'h55, 8'h00, 2, 4'b0111, 1, 16'h1E55, 0};
        tbl[1] = '{8'h36, 8'hAB, 8'hCD, 8'h00, 2, 4'b0000, 0, 16'h1E55, 0};
        tbl[2] = '{8'h35, 8'h00, 8'h00, 8'h00, 0, 4'b0000, 0, 16'h1E55, 0};
        tbl[3] = '{8'h34, 8'hC3, 8'h3C, 8'hE7, 3, 4'b0111, 1, 16'hC33C, 0};
        tbl[4] = '{8'h34, 8'h77, 8'h00, 8'h00, 1, 4'b0011, 0, 16'hC33C, 1};
        tbl[5] = '{8'h34, 8'h00, 8'h00, 8'h00, 0, 4'b0001, 0, 16'hC33C, 1};
        tbl[6] = '{8'h00, 8'h12, 8'h34, 8'h00, 2, 4'b0000, 0, 16'hC33C, 0};
        tbl[7] = '{8'h34, 8'h00, 8'hFF, 8'h00, 2, 4'b0111, 1, 16'h00FF, 0};

        tick(3);
        chk("rst_regdata", 32'(regdata), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_sda", 32'(sda), 32'd1);
        reset_n = 1'b1;
        tick(8);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            rv.d1 = 8'($urandom); rv.d2 = 8'($urandom); rv.d3 = 8'($urandom);
            rv.nd = int'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1:    rv.adr = 8'h34;
                2:       rv.adr = 8'h35;
                default: rv.adr = 8'($urandom);
            endcase
            run_vec(model(rv, model_reg), $sformatf("rnd%0d", i));
        end

        // STOP after four bits of the second data byte.
        v0 = cnt_valid; e0 = cnt_errp;
        bus_start();
        send_byte(8'h34, ak, bs);
        send_byte(8'h12, ak, bs);
        chk("stopmid_ack1", 32'(ak), 32'd1);
        send_bits(8'hA0, 4);
        bus_stop();
        chk("stopmid_error", 32'(cnt_errp - e0), 32'd1);
        chk("stopmid_valid", 32'(cnt_valid - v0), 32'd0);
        chk("stopmid_regdata", 32'(regdata), 32'(model_reg));
        chk("stopmid_busy", 32'(busy), 32'd0);

        // Repeated START aborts the first write, second write completes.
        v0 = cnt_valid; e0 = cnt_errp;
        bus_start();
        send_byte(8'h34, ak, bs);
        send_byte(8'hAA, ak, bs);
        bus_start();
        send_byte(8'h34, ak, bs);
        chk("rstart_ack_adr", 32'(ak), 32'd1);
        send_byte(8'h01, ak, bs);
        send_byte(8'h02, ak, bs);
        bus_stop();
        chk("rstart_error", 32'(cnt_errp - e0), 32'd1);
        chk("rstart_valid", 32'(cnt_valid - v0), 32'd1);
        chk("rstart_regdata", 32'(regdata), 32'h0102);

        // Third data byte is NACKed, valid still fires once.
        v0 = cnt_valid;
        bus_start();
        send_byte(8'h34, ak, bs);
        send_byte(8'h11, ak, bs);
        send_byte(8'h22, ak, bs);
        send_byte(8'h33, ak, bs);
        chk("extra_nack", 32'(ak), 32'd0);
        bus_stop();
        chk("extra_valid", 32'(cnt_valid - v0), 32'd1);
        chk("extra_regdata", 32'(regdata), 32'h1122);

        // Reset while the address ACK is being driven.
        bus_start();
        send_bits(8'h34, 8);
        tick(4); m_drv0 = 1'b0;
        tick(4); scl_r = 1'b1;
        tick(4);
        chk("rstack_driven", 32'(sda), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rstack_sda_rel", 32'(sda), 32'd1);
        chk("rstack_regdata", 32'(regdata), 32'd0);
        chk("rstack_busy", 32'(busy), 32'd0);
        chk("rstack_valid", 32'(valid), 32'd0);
        chk("rstack_error", 32'(error), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2); scl_r = 1'b0;
        e0 = cnt_errp;
        send_byte(8'h34, ak, bs);
        chk("postrst_idle_nack", 32'(ak), 32'd0);
        bus_stop();
        chk("postrst_no_error", 32'(cnt_errp - e0), 32'd0);
        rv = '{8'h34, 8'hBE, 8'hEF, 8'h00, 2, 4'b0111, 1, 16'hBEEF, 0};
        run_vec(rv, "postrst_write");

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end

endmodule
